// File: rtl/mac_issue_arbiter.sv
// Round-robin issue arbiter that shares one non-stallable pipelined MAC between
// NREQ requesters and routes each result back to its issuer through a tag pipe.
module mac_issue_arbiter #(
    parameter int NREQ    = 4,
    parameter int W       = 16,
    parameter int RW      = 33,
    parameter int LATENCY = 7,
    parameter int MAXOUT  = 4
) (
    input  logic              clk,
    input  logic              aclr,
    input  logic [NREQ-1:0]   i_req_valid,
    output logic [NREQ-1:0]   o_req_ready,
    input  logic [NREQ*W-1:0] i_req_a,
    input  logic [NREQ*W-1:0] i_req_b,
    input  logic [NREQ*W-1:0] i_req_c,
    input  logic              i_hold,
    output logic              o_mac_valid,
    output logic [W-1:0]      o_mac_a,
    output logic [W-1:0]      o_mac_b,
    output logic [W-1:0]      o_mac_c,
    input  logic              i_mac_out_valid,
    input  logic [RW-1:0]     i_mac_result,
    output logic [NREQ-1:0]   o_resp_valid,
    output logic [RW-1:0]     o_resp_data,
    output logic              o_busy,
    output logic              o_err
);

    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(MAXOUT + 1);

    logic [IDW-1:0]  r_rrPtr;
    logic            r_macValid;
    logic [W-1:0]    r_macA;
    logic [W-1:0]    r_macB;
    logic [W-1:0]    r_macC;
    logic [IDW-1:0]  r_issueId;
    logic [LATENCY-1:0] r_tagValid;
    logic [IDW-1:0]  r_tagId [LATENCY];
    logic [NREQ-1:0] r_respValid;
    logic [RW-1:0]   r_respData;
    logic            r_err;
    logic [CW-1:0]   r_cnt [NREQ];

    logic [NREQ-1:0] w_elig;
    logic [NREQ-1:0] w_nonZero;
    logic [NREQ-1:0] w_grant;
    logic            w_grantValid;
    logic [IDW-1:0]  w_grantId;
    logic [IDW:0]    w_sum;
    logic [IDW-1:0]  w_cand;
    logic [W-1:0]    w_selA;
    logic [W-1:0]    w_selB;
    logic [W-1:0]    w_selC;

    // Only the registered count gates eligibility, so a same-cycle response never frees a slot.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_elig
        assign w_elig[gi]    = i_req_valid[gi] && !i_hold && !aclr && (r_cnt[gi] < CW'(MAXOUT));
        assign w_nonZero[gi] = (r_cnt[gi] != '0);
    end

    always_comb begin
        w_grant      = '0;
        w_grantValid = 1'b0;
        w_grantId    = '0;
        w_sum        = '0;
        w_cand       = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_sum = {1'b0, r_rrPtr} + (IDW+1)'(k);
            if (w_sum >= (IDW+1)'(NREQ)) begin
                w_sum = w_sum - (IDW+1)'(NREQ);
            end
            w_cand = w_sum[IDW-1:0];
            if (!w_grantValid && w_elig[w_cand]) begin
                w_grantValid = 1'b1;
                w_grantId    = w_cand;
            end
        end
        if (w_grantValid) begin
            w_grant = NREQ'(1) << w_grantId;
        end
    end

    always_comb begin
        w_selA = '0;
        w_selB = '0;
        w_selC = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_selA = i_req_a[i*W +: W];
                w_selB = i_req_b[i*W +: W];
                w_selC = i_req_c[i*W +: W];
            end
        end
    end

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            r_rrPtr    <= IDW'(NREQ - 1);
            r_macValid <= 1'b0;
            r_macA     <= '0;
            r_macB     <= '0;
            r_macC     <= '0;
            r_issueId  <= '0;
        end else begin
            r_macValid <= w_grantValid;
            if (w_grantValid) begin
                r_rrPtr   <= w_grantId;
                r_macA    <= w_selA;
                r_macB    <= w_selB;
                r_macC    <= w_selC;
                r_issueId <= w_grantId;
            end
        end
    end

    // The tag pipe shadows the MAC latency; its last stage lines up with i_mac_out_valid.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            r_tagValid <= '0;
            for (int s = 0; s < LATENCY; s++) begin
                r_tagId[s] <= '0;
            end
        end else begin
            r_tagValid <= {r_tagValid[LATENCY-2:0], r_macValid};
            r_tagId[0] <= r_issueId;
            for (int s = 1; s < LATENCY; s++) begin
                r_tagId[s] <= r_tagId[s-1];
            end
        end
    end

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            r_respValid <= '0;
            r_respData  <= '0;
            r_err       <= 1'b0;
        end else begin
            r_respValid <= r_tagValid[LATENCY-1] ? (NREQ'(1) << r_tagId[LATENCY-1]) : '0;
            if (r_tagValid[LATENCY-1]) begin
                r_respData <= i_mac_result;
            end
            if (i_mac_out_valid != r_tagValid[LATENCY-1]) begin
                r_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            for (int i = 0; i < NREQ; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (w_grant[i] && !r_respValid[i]) begin
                    r_cnt[i] <= r_cnt[i] + CW'(1);
                end else if (!w_grant[i] && r_respValid[i]) begin
                    r_cnt[i] <= r_cnt[i] - CW'(1);
                end
            end
        end
    end

    assign o_req_ready  = w_grant;
    assign o_mac_valid  = r_macValid;
    assign o_mac_a      = r_macA;
    assign o_mac_b      = r_macB;
    assign o_mac_c      = r_macC;
    assign o_resp_valid = r_respValid;
    assign o_resp_data  = r_respData;
    assign o_busy       = |w_nonZero;
    assign o_err        = r_err;

endmodule
